// File: rtl/fifo_arb_pkg.sv
// Shared defaults and read-buffer occupancy encoding for the FIFO arbiter.
package fifo_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DW_DEF      = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_arbiter_rr_arbiter.sv
// Round-robin grant: first requester above the last grant, wrapping around.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_grant_idx,
  output logic               o_grant_vld
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  // Offsets 1..NUM_REQ so the last grantee is considered last.
  always_comb begin
    w_found     = 1'b0;
    w_idx       = '0;
    o_grant     = '0;
    o_grant_idx = i_last_grant;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = IW'((32'(i_last_grant) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
    o_grant_vld = w_found;
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin multi-writer front end to a shared FIFO, with a 2-entry
// prefetch buffer driving a valid/ready consumer on the read side.
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter  int unsigned DW      = DW_DEF,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  fifo_cs,
  output logic                  fifo_wr_en,
  output logic [DW-1:0]         fifo_data_in,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [DW-1:0]         fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [IW-1:0]         last_grant
);

  // ---------------- write side ----------------
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_grant_idx;
  logic               w_grant_vld;
  logic               w_wr_fire;
  logic [IW-1:0]      r_last_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_grant_vld  (w_grant_vld)
  );

  // rst_n gating keeps the write strobes quiet while reset is held.
  assign w_wr_fire    = rst_n & w_grant_vld & ~fifo_full;
  assign req_ready    = w_wr_fire ? w_grant : '0;
  assign fifo_wr_en   = w_wr_fire;
  assign fifo_data_in = w_wr_fire ? req_data[w_grant_idx*DW +: DW] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= IW'(NUM_REQ - 1);
    end else if (w_wr_fire) begin
      r_last_grant <= w_grant_idx;
    end
  end

  assign last_grant = r_last_grant;

  // ---------------- read side ----------------
  occ_e          r_occ;
  occ_e          w_occ_nxt;
  logic          r_in_flight;
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;
  logic [DW-1:0] w_buf0_nxt;
  logic [DW-1:0] w_buf1_nxt;
  logic          w_pop;
  logic          w_rd_en;
  logic [2:0]    w_level;

  // Prefetch only while buffered + in-flight words, net of this pop, leave room.
  assign w_pop   = out_valid & out_ready;
  assign w_level = 3'(r_occ) + 3'(r_in_flight) - 3'(w_pop);
  assign w_rd_en = rst_n & ~fifo_empty & (w_level < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ       <= EMPTY;
      r_in_flight <= 1'b0;
      r_buf0      <= '0;
      r_buf1      <= '0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_in_flight <= w_rd_en;
      r_buf0      <= w_buf0_nxt;
      r_buf1      <= w_buf1_nxt;
    end
  end

  // Returning word lands at the tail; a pop shifts entry 1 into the head.
  always_comb begin
    w_occ_nxt  = r_occ;
    w_buf0_nxt = r_buf0;
    w_buf1_nxt = r_buf1;
    case ({r_in_flight, w_pop})
      2'b10: begin
        if (r_occ == EMPTY) begin
          w_buf0_nxt = fifo_data_out;
          w_occ_nxt  = ONE;
        end else begin
          w_buf1_nxt = fifo_data_out;
          w_occ_nxt  = TWO;
        end
      end
      2'b01: begin
        if (r_occ == TWO) begin
          w_buf0_nxt = r_buf1;
          w_occ_nxt  = ONE;
        end else begin
          w_occ_nxt  = EMPTY;
        end
      end
      2'b11: begin
        if (r_occ == TWO) begin
          w_buf0_nxt = r_buf1;
          w_buf1_nxt = fifo_data_out;
        end else begin
          w_buf0_nxt = fifo_data_out;
        end
      end
      default: ;
    endcase
  end

  assign out_valid  = (r_occ != EMPTY);
  assign out_data   = r_buf0;
  assign fifo_rd_en = w_rd_en;
  assign fifo_cs    = fifo_wr_en | fifo_rd_en;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a behavioural 16-deep FIFO attached.
module tb_fifo_arbiter;

  localparam int unsigned NR    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_cs;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data_in;
  logic              fifo_full;
  logic              fifo_rd_en;
  logic [DW-1:0]     fifo_data_out;
  logic              fifo_empty;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        last_grant;

  logic              force_full;
  logic [DW-1:0]     m_q[$];
  logic              m_empty;
  logic              m_full;
  logic [DW-1:0]     m_dout;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  int got;

  always #5 clk = ~clk;

  fifo_arbiter #(.NUM_REQ(NR), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_cs       (fifo_cs),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .last_grant    (last_grant)
  );

  // Behavioural FIFO: registered flags, read data one cycle after rd_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_empty <= 1'b1;
      m_full  <= 1'b0;
      m_dout  <= '0;
    end else begin
      if (fifo_rd_en && m_q.size() > 0) begin
        m_dout <= m_q[0];
        void'(m_q.pop_front());
      end
      if (fifo_wr_en) m_q.push_back(fifo_data_in);
      m_empty <= (m_q.size() == 0);
      m_full  <= (m_q.size() >= DEPTH);
    end
  end

  assign fifo_full     = m_full | force_full;
  assign fifo_empty    = m_empty;
  assign fifo_data_out = m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = '0;
    out_ready  = 1'b0;
    force_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    out_ready  = 1'b0;
    force_full = 1'b0;
    #2;
    // Reset held with every input asserting activity
    rst_n     = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_slot(i, 32'(32'h1000 + i * 32'h11));
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_en",     32'(fifo_wr_en), 32'h0);
    chk("rst_cs",        32'(fifo_cs), 32'h0);
    chk("rst_rd_en",     32'(fifo_rd_en), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_last_grant",32'(last_grant), 32'h3);
    chk("rst_out_data",  out_data, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;

    // All four requesters: strict rotation 0,1,2,3,0,1,2,3
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr4_ready", 32'(req_ready), 32'(1 << (c % 4)));
      chk("rr4_data",  fifo_data_in, 32'(32'h1000 + (c % 4) * 32'h11));
      chk("rr4_cs",    32'(fifo_cs), 32'h1);
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    chk("rr4_last_grant", 32'(last_grant), 32'h3);
    chk("rr4_idle_wr",    32'(fifo_wr_en), 32'h0);

    // Single requester 2, full pulsed on cycle 3
    do_reset();
    req_valid = 4'b0100;
    set_slot(2, 32'h222);
    for (int c = 0; c < 6; c++) begin
      force_full = (c == 3);
      #1;
      chk("full_ready", 32'(req_ready), (c == 3) ? 32'h0 : 32'h4);
      chk("full_wr_en", 32'(fifo_wr_en), (c == 3) ? 32'h0 : 32'h1);
      if (c == 0) chk("full_lg_start", 32'(last_grant), 32'h3);
      if (c == 3) chk("full_lg_hold",  32'(last_grant), 32'h2);
      @(negedge clk);
    end
    force_full = 1'b0;
    req_valid  = '0;

    // Requesters 1 and 3 alternate starting after last_grant=3
    do_reset();
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("alt_ready", 32'(req_ready), (c % 2 == 0) ? 32'h2 : 32'h8);
      @(negedge clk);
    end
    req_valid = '0;

    // Streaming 0xA0..0xA7 with consumer always ready
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 8) ? 4'b0001 : 4'b0000;
      set_slot(0, 32'(32'hA0 + c));
      #1;
      chk("stream_rd_en",  32'(fifo_rd_en), 32'(c >= 1 && c <= 8));
      chk("stream_valid",  32'(out_valid),  32'(c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) chk("stream_data", out_data, 32'(32'hA0 + c - 3));
      @(negedge clk);
    end
    req_valid = '0;

    // Backpressure: five words, consumer stalled, then released
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 5) ? 4'b0010 : 4'b0000;
      set_slot(1, 32'(32'hB0 + c));
      #1;
      if (c >= 4) begin
        chk("bp_rd_en",  32'(fifo_rd_en), 32'h0);
        chk("bp_valid",  32'(out_valid), 32'h1);
        chk("bp_hold",   out_data, 32'hB0);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && got < 5; t++) begin
      #1;
      if (out_valid) begin
        chk("bp_data", out_data, 32'(32'hB0 + got));
        got++;
      end
      @(negedge clk);
    end
    chk("bp_count", 32'(got), 32'h5);
    #1;
    chk("bp_drained", 32'(out_valid), 32'h0);

    // Reset while a word is in flight and one is buffered
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid = (c < 2) ? 4'b0010 : 4'b0000;
      set_slot(1, 32'(32'hC0 + c));
      @(negedge clk);
    end
    #1;
    chk("mid_pre_valid", 32'(out_valid), 32'h1);
    chk("mid_pre_lg",    32'(last_grant), 32'h1);
    chk("mid_pre_data",  out_data, 32'hC0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_lg",    32'(last_grant), 32'h3);
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'h0);
    chk("mid_rst_data",  out_data, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("mid_no_stale", 32'(out_valid), 32'h0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
